fb_rect_fill: RTL and testbench

Frame-buffer writer that fills axis-aligned rectangles of a single 12-bit colour into the 640×480, one-pixel-per-word display memory. It is the write-side counterpart to the VGA scan-out reader: it uses the same linear addressing (addr = y*640 + x) and word format (colour in bits [11:0]). It drives the write port of the dual-port frame buffer. It accepts one command at a time over a valid/ready handshake and issues one memory write per pixel, honouring memory back-pressure.

---
 rtl/fb_rect_fill.sv | 190 +++++++++++++++++++
 tb/tb_fb_rect_fill.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle filler for the 640x480 frame buffer: one write per pixel at y*640+x, honouring mem_wready.
// Optional feature macro FB_CLIP_EN: clip rectangles to the frame instead of rejecting them with err.

module fb_rect_fill #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [9:0]        cmd_x0_i,
    input  logic [9:0]        cmd_y0_i,
    input  logic [9:0]        cmd_w_i,
    input  logic [9:0]        cmd_h_i,
    input  logic [11:0]       cmd_color_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_wready_i
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
`ifndef FB_CLIP_EN
        ERR,
`endif
        DONE
    } state_t;

    localparam logic [10:0]       H_LIM      = 11'(H_RES);
    localparam logic [10:0]       V_LIM      = 11'(V_RES);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);

    state_t              state_q;
    logic [9:0]          x0_q, y0_q, w_q, h_q, x_q, y_q;
    logic [11:0]         color_q;
    logic [10:0]         xEnd_q, yEnd_q;
    logic [ADDR_W-1:0]   rowBase_q;
    logic                cmdReady_q, busy_q, done_q, memWe_q;
    logic [ADDR_W-1:0]   memAddr_q;
    logic [DATA_W-1:0]   memWdata_q;

    logic [10:0]         xSum, ySum, xEnd_d, yEnd_d, xNext, yNext;
    logic [ADDR_W-1:0]   y0Ext, x0Ext, rowBase_d;
    logic                empty_d, writeDone;

    // Sums are 11 bits so x0+w never wraps; row base uses 640 = 512 + 128 shift-add.
    always_comb begin
        xSum      = {1'b0, x0_q} + {1'b0, w_q};
        ySum      = {1'b0, y0_q} + {1'b0, h_q};
        y0Ext     = ADDR_W'(y0_q);
        x0Ext     = ADDR_W'(x0_q);
        rowBase_d = (y0Ext << 9) + (y0Ext << 7);
        xNext     = {1'b0, x_q} + 11'd1;
        yNext     = {1'b0, y_q} + 11'd1;
        writeDone = memWe_q && mem_wready_i;
`ifdef FB_CLIP_EN
        xEnd_d  = (xSum > H_LIM) ? H_LIM : xSum;
        yEnd_d  = (ySum > V_LIM) ? V_LIM : ySum;
        empty_d = ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM)
                  || (w_q == 10'd0) || (h_q == 10'd0);
`else
        xEnd_d  = xSum;
        yEnd_d  = ySum;
        empty_d = (w_q == 10'd0) || (h_q == 10'd0);
`endif
    end

`ifndef FB_CLIP_EN
    logic err_q;
    logic reject_d;
    assign reject_d = (xSum > H_LIM) || (ySum > V_LIM);
    assign err_o    = err_q;
`else
    assign err_o    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            color_q    <= '0;
            xEnd_q     <= '0;
            yEnd_q     <= '0;
            rowBase_q  <= '0;
            cmdReady_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
`ifndef FB_CLIP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifndef FB_CLIP_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        x0_q       <= cmd_x0_i;
                        y0_q       <= cmd_y0_i;
                        w_q        <= cmd_w_i;
                        h_q        <= cmd_h_i;
                        color_q    <= cmd_color_i;
                        cmdReady_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    xEnd_q     <= xEnd_d;
                    yEnd_q     <= yEnd_d;
                    rowBase_q  <= rowBase_d;
                    x_q        <= x0_q;
                    y_q        <= y0_q;
                    memWdata_q <= DATA_W'(color_q);
`ifndef FB_CLIP_EN
                    if (reject_d) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else
`endif
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        memWe_q   <= 1'b1;
                        memAddr_q <= rowBase_d + x0Ext;
                        state_q   <= WRITE;
                    end
                end
                WRITE: begin
                    // Address and data only move on an accepted write, so stalls hold them stable.
                    if (writeDone) begin
                        if (xNext < xEnd_q) begin
                            x_q       <= xNext[9:0];
                            memAddr_q <= rowBase_q + ADDR_W'(xNext);
                        end else if (yNext < yEnd_q) begin
                            x_q       <= x0_q;
                            y_q       <= yNext[9:0];
                            rowBase_q <= rowBase_q + ROW_STRIDE;
                            memAddr_q <= rowBase_q + ROW_STRIDE + x0Ext;
                        end else begin
                            memWe_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
`ifndef FB_CLIP_EN
                ERR: begin
                    cmdReady_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
`endif
                DONE: begin
                    cmdReady_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmdReady_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Testbench for fb_rect_fill: vector table, randomized commands against a pixel-list model,
// plus back-to-back and mid-write reset sequences. Honours FB_CLIP_EN when defined.

module tb_fb_rect_fill;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 19;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [9:0]    cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [11:0]   cmd_color;
    logic          busy, done, err, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready = 1'b1;

    fb_rect_fill #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_x0_i     (cmd_x0),
        .cmd_y0_i     (cmd_y0),
        .cmd_w_i      (cmd_w),
        .cmd_h_i      (cmd_h),
        .cmd_color_i  (cmd_color),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wready_i (mem_wready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    typedef struct {
        string name;
        int    x0, y0, w, h, color, mode;
        int    expN;
        bit    expErr;
        int    expFirst;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   wrMode = 0;
    wr_t  writes[$];
    int   expAddr[$];
    int   doneCnt = 0;
    int   errCnt = 0;
    logic          prevStall = 1'b0;
    logic [AW-1:0] prevAddr;
    logic [DW-1:0] prevData;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    always @(posedge clk) begin
        #1;
        case (wrMode)
            0:       mem_wready = 1'b1;
            1:       mem_wready = ~mem_wready;
            default: mem_wready = 1'($urandom_range(0, 1));
        endcase
    end

    // Write/pulse monitor, sampled mid-cycle; also checks that stalled writes hold their payload.
    always @(negedge clk) begin
        if (!rstn) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_we", mem_we, 1);
                checkOutput("stall_addr", mem_addr, prevAddr);
                checkOutput("stall_data", mem_wdata, prevData);
            end
            if (mem_we && mem_wready)
                writes.push_back('{addr: mem_addr, data: mem_wdata, cyc: cycleCnt});
            prevStall = mem_we && !mem_wready;
            prevAddr  = mem_addr;
            prevData  = mem_wdata;
            if (done) doneCnt++;
            if (err)  errCnt++;
        end
    end

    // Reference: list every pixel address of the rectangle, row by row.
    task automatic modelCmd(input int x0, input int y0, input int w, input int h, output bit expErr);
        int xe, ye;
        expAddr.delete();
        expErr = 1'b0;
`ifdef FB_CLIP_EN
        xe = (x0 + w > H) ? H : x0 + w;
        ye = (y0 + h > V) ? V : y0 + h;
        if (x0 >= H || y0 >= V) begin
            xe = x0;
            ye = y0;
        end
`else
        xe = x0 + w;
        ye = y0 + h;
        if (x0 + w > H || y0 + h > V) begin
            expErr = 1'b1;
            return;
        end
`endif
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                expAddr.push_back(y * H + x);
    endtask

    task automatic driveCmd(input int x0, input int y0, input int w, input int h, input int color);
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 12'(color);
    endtask

    task automatic waitEnd(input string tag, input int budget, output int endCyc);
        bit finished = 1'b0;
        int badFlags = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            @(negedge clk);
            if (cmd_ready || !busy) badFlags++;
            if (done || err) finished = 1'b1;
        end
        endCyc = cycleCnt;
        checkOutput({tag, "_finished"}, finished, 1);
        checkOutput({tag, "_busy_noready"}, badFlags, 0);
    endtask

    task automatic compareWrites(input string tag, input int color);
        int bad = 0;
        checkOutput({tag, "_nwrites"}, writes.size(), expAddr.size());
        foreach (writes[i]) begin
            if (i >= expAddr.size()) bad++;
            else if (writes[i].addr != AW'(expAddr[i]) || writes[i].data != DW'(color)) bad++;
        end
        checkOutput({tag, "_addr_data_bad"}, bad, 0);
    endtask

    task automatic applyStimulus(input string tag, input int x0, input int y0, input int w,
                                 input int h, input int color, input int mode);
        bit expErr;
        int tAcc, endCyc, expEnd;
        modelCmd(x0, y0, w, h, expErr);
        wrMode = mode;
        @(posedge clk); #1;
        driveCmd(x0, y0, w, h, color);
        cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, cmd_ready, 1);
        tAcc = cycleCnt;
        writes.delete();
        doneCnt = 0;
        errCnt = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        driveCmd($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), $urandom_range(0, 4095));
        waitEnd(tag, 8 * expAddr.size() + 40, endCyc);
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, cmd_ready, 1);
        checkOutput({tag, "_busy_after"}, busy, 0);
        checkOutput({tag, "_err_pulses"}, errCnt, expErr ? 1 : 0);
        checkOutput({tag, "_done_pulses"}, doneCnt, expErr ? 0 : 1);
        compareWrites(tag, color);
        if (expErr || expAddr.size() == 0) expEnd = tAcc + 2;
        else if (mode == 0) expEnd = tAcc + 2 + expAddr.size();
        else expEnd = (writes.size() > 0) ? writes[writes.size() - 1].cyc + 1 : -1;
        checkOutput({tag, "_end_cycle"}, endCyc, expEnd);
    endtask

    vec_t vecs[$];

    initial begin
        int tA, tB, tR, endCyc;
        bit eErr;
        bit reached;

        vecs.push_back('{"basic",    10,  2,   3, 2, 'hABC, 0, 6,  1'b0, 1290});
        vecs.push_back('{"backpres", 10,  2,   3, 2, 'hABC, 1, 6,  1'b0, 1290});
        vecs.push_back('{"empty_w",  40,  9,   0, 5, 'h111, 0, 0,  1'b0, 0});
        vecs.push_back('{"empty_h",   5,  5,   7, 0, 'h222, 0, 0,  1'b0, 0});
        vecs.push_back('{"single",    0,  0,   1, 1, 'hFFF, 0, 1,  1'b0, 0});
        vecs.push_back('{"fullrow",   0, 479, 640, 1, 'h5A5, 0, 640, 1'b0, 306560});
        vecs.push_back('{"randrdy", 100, 100,  5, 4, 'h0F0, 2, 20, 1'b0, 64100});
`ifdef FB_CLIP_EN
        vecs.push_back('{"edge",    638, 479,  4, 1, 'h123, 0, 2,  1'b0, 307198});
        vecs.push_back('{"ovf_y",     0, 470,  2, 20, 'h321, 0, 20, 1'b0, 300800});
        vecs.push_back('{"offframe", 700, 10,  3, 3, 'h777, 0, 0,  1'b0, 0});
`else
        vecs.push_back('{"edge",    638, 479,  4, 1, 'h123, 0, 0,  1'b1, 0});
        vecs.push_back('{"ovf_y",     0, 470,  2, 20, 'h321, 0, 0,  1'b1, 0});
`endif

        rstn = 1'b0;
        cmd_valid = 1'b0;
        driveCmd(0, 0, 0, 0, 0);
        #12;
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].name, vecs[k].x0, vecs[k].y0, vecs[k].w, vecs[k].h,
                          vecs[k].color, vecs[k].mode);
            checkOutput({vecs[k].name, "_tbl_n"}, writes.size(), vecs[k].expN);
            checkOutput({vecs[k].name, "_tbl_err"}, errCnt, vecs[k].expErr ? 1 : 0);
            if (vecs[k].expN > 0)
                checkOutput({vecs[k].name, "_tbl_first"},
                            (writes.size() > 0) ? longint'(writes[0].addr) : -1, vecs[k].expFirst);
        end

        for (int r = 0; r < 25; r++) begin
            int x0, y0, w, h;
            if ($urandom_range(0, 3) == 0) begin
                x0 = $urandom_range(620, 639);
                y0 = $urandom_range(470, 479);
                w  = $urandom_range(1, 30);
                h  = $urandom_range(1, 15);
            end else begin
                x0 = $urandom_range(0, 600);
                y0 = $urandom_range(0, 460);
                w  = $urandom_range(0, 12);
                h  = $urandom_range(0, 6);
            end
            applyStimulus($sformatf("rand%0d", r), x0, y0, w, h, $urandom_range(0, 4095),
                          $urandom_range(0, 2));
        end

        // Back-to-back: second command waits on cmd_valid while the first runs.
        wrMode = 0;
        @(posedge clk); #1;
        driveCmd(0, 10, 3, 1, 'h123);
        cmd_valid = 1'b1;
        @(negedge clk);
        checkOutput("b2b_readyA", cmd_ready, 1);
        tA = cycleCnt;
        writes.delete();
        doneCnt = 0;
        @(posedge clk); #1;
        driveCmd(5, 20, 2, 2, 'h456);
        waitEnd("b2bA", 40, endCyc);
        checkOutput("b2b_doneA_cycle", endCyc, tA + 2 + 3);
        checkOutput("b2b_writesA", writes.size(), 3);
        @(negedge clk);
        checkOutput("b2b_readyB", cmd_ready, 1);
        checkOutput("b2b_acceptB_cycle", cycleCnt, endCyc + 1);
        tB = cycleCnt;
        writes.delete();
        doneCnt = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        modelCmd(5, 20, 2, 2, eErr);
        waitEnd("b2bB", 40, endCyc);
        checkOutput("b2b_doneB_cycle", endCyc, tB + 2 + 4);
        compareWrites("b2bB", 'h456);

        // Reset during the third write of an eight-pixel row.
        @(negedge clk);
        @(posedge clk); #1;
        driveCmd(0, 1, 8, 1, 'h9AB);
        cmd_valid = 1'b1;
        @(negedge clk);
        tR = cycleCnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (cycleCnt == tR + 4) reached = 1'b1;
        end
        checkOutput("rstmid_reached", reached, 1);
        checkOutput("rstmid_we_before", mem_we, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rstmid_we", mem_we, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_ready", cmd_ready, 1);
        checkOutput("rstmid_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        writes.delete();
        doneCnt = 0;
        repeat (10) @(negedge clk);
        checkOutput("rstmid_nowrites", writes.size(), 0);
        checkOutput("rstmid_nodone", doneCnt, 0);
        checkOutput("rstmid_ready_after", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
